// File: rtl/sal_wr_issue_ctrl.sv
// sal_wr_issue_ctrl: write-command issue stage in front of the write-data controller.
// Grants a queued DRAM write once enough W beats are buffered, the bank is open
// and write-to-write / read-to-write spacing is met, then tracks tWTR and per-bank tWR.
module sal_wr_issue_ctrl #(
  parameter int NUM_BANKS  = 16,
  parameter int COL_W      = 10,
  parameter int CREDIT_MAX = 8,
  parameter int CNT_W      = 6,
  localparam int BA_W      = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req_valid,
  input  logic [BA_W-1:0]      wr_req_bank,
  input  logic [COL_W-1:0]     wr_req_col,
  output logic                 wr_req_ready,
  input  logic [NUM_BANKS-1:0] bank_ready,
  input  logic                 w_beat,
  input  logic                 rd_gnt,
  input  logic [3:0]           t_ccd,
  input  logic [3:0]           t_rtw,
  input  logic [3:0]           t_wtr,
  input  logic [4:0]           t_wr,
  input  logic [3:0]           dfi_wren_lat,
  output logic                 wr_gnt,
  output logic [BA_W-1:0]      wr_gnt_bank,
  output logic [COL_W-1:0]     wr_gnt_col,
  output logic                 rd_block,
  output logic [NUM_BANKS-1:0] pre_block,
  output logic                 credit_err
);

  localparam int CRD_W = $clog2(CREDIT_MAX + 1);
  localparam int SUM_W = (CNT_W > 7) ? CNT_W + 1 : 8;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CRD_W-1:0] credits;
  logic [CNT_W-1:0] ccd_cnt;
  logic [CNT_W-1:0] rtw_cnt;
  logic [CNT_W-1:0] wtr_cnt;
  logic [CNT_W-1:0] twr_cnt [NUM_BANKS];

  logic [SUM_W-1:0] ccd_sum;
  logic [SUM_W-1:0] wtr_sum;
  logic [SUM_W-1:0] twr_sum;

  // Clamp a reload value so a counter can never be loaded past its range
  function automatic logic [CNT_W-1:0] sat_load(input logic [SUM_W-1:0] v);
    if (v > CNT_MAX) return '1;
    return v[CNT_W-1:0];
  endfunction

  // Reload amounts; the burst is 2 beats so spacing below 2 cycles would overlap data
  always_comb begin
    ccd_sum = (t_ccd < 4'd2) ? SUM_W'(1) : SUM_W'(t_ccd) - SUM_W'(1);
    wtr_sum = SUM_W'(dfi_wren_lat) + SUM_W'(2) + SUM_W'(t_wtr);
    twr_sum = SUM_W'(dfi_wren_lat) + SUM_W'(2) + SUM_W'(t_wr);
  end

  // Grant decision; a read issued this cycle always wins over a write
  always_comb begin
    wr_gnt = wr_req_valid && bank_ready[wr_req_bank] && (credits >= CRD_W'(2))
             && (ccd_cnt == '0) && (rtw_cnt == '0) && !rd_gnt;
    wr_req_ready = wr_gnt;
    wr_gnt_bank  = wr_gnt ? wr_req_bank : '0;
    wr_gnt_col   = wr_gnt ? wr_req_col : '0;
    rd_block     = (wtr_cnt != '0);
    for (int b = 0; b < NUM_BANKS; b++) begin
      pre_block[b] = (twr_cnt[b] != '0);
    end
  end

  // Write-data credits: one per buffered beat, a grant consumes a 2-beat burst
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else if (wr_gnt) begin
      credits <= credits - CRD_W'(2) + CRD_W'(w_beat);
    end else if (w_beat && (credits != CRD_W'(CREDIT_MAX))) begin
      credits <= credits + CRD_W'(1);
    end
  end

  // Sticky overflow flag: a beat arrived while the FIFO was already full
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err <= 1'b0;
    end else if (w_beat && !wr_gnt && (credits == CRD_W'(CREDIT_MAX))) begin
      credit_err <= 1'b1;
    end
  end

  // Write-to-write spacing counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ccd_cnt <= '0;
    end else if (wr_gnt) begin
      ccd_cnt <= sat_load(ccd_sum);
    end else if (ccd_cnt != '0) begin
      ccd_cnt <= ccd_cnt - CNT_W'(1);
    end
  end

  // Read-to-write turnaround counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rtw_cnt <= '0;
    end else if (rd_gnt) begin
      rtw_cnt <= sat_load(SUM_W'(t_rtw));
    end else if (rtw_cnt != '0) begin
      rtw_cnt <= rtw_cnt - CNT_W'(1);
    end
  end

  // Write-to-read counter; the most recent write restarts the window
  always_ff @(posedge clk) begin
    if (rst) begin
      wtr_cnt <= '0;
    end else if (wr_gnt) begin
      wtr_cnt <= sat_load(wtr_sum);
    end else if (wtr_cnt != '0) begin
      wtr_cnt <= wtr_cnt - CNT_W'(1);
    end
  end

  // Per-bank write recovery counters guarding precharge
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rst) begin
        twr_cnt[b] <= '0;
      end else if (wr_gnt && (wr_req_bank == BA_W'(b))) begin
        twr_cnt[b] <= sat_load(twr_sum);
      end else if (twr_cnt[b] != '0) begin
        twr_cnt[b] <= twr_cnt[b] - CNT_W'(1);
      end
    end
  end

endmodule
